// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master and slave cores: default word size, mode constants
// and the slave FSM state encoding.
package spi_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    // Mode 0: sclk idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift
    } spi_state_e;

endpackage

// File: rtl/spi_slave_core_if.sv
// Local-side interface of the SPI slave core: TX holding register handshake, RX word strobe
// and status strobes.
interface spi_slave_core_if #(
    parameter int unsigned DATA_WIDTH = spi_pkg::DEFAULT_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_underrun;
    logic                  frame_error;
    logic                  busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, tx_underrun, frame_error, busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, tx_underrun, frame_error, busy
    );

endinterface

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, followed by a history flop for
// rise/fall detection.
module spi_in_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Everything resets low, so a pin that is already low when reset lifts produces no edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 responder: oversampled sclk/ss_n/mosi, MSB-first DATA_WIDTH-bit words,
// one-entry TX holding register and RX word strobe.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sclk,
    input  logic            ss_n,
    input  logic            mosi,
    output logic            miso,
    output logic            miso_oe,
    spi_slave_core_if.slave bus
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic ss_sync, ss_rise, ss_fall;
    logic mosi_sync, mosi_rise, mosi_fall;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .reset(reset), .din(sclk), .dout(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
        .clk(clk), .reset(reset), .din(ss_n), .dout(ss_sync), .rise(ss_rise), .fall(ss_fall)
    );
    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk(clk), .reset(reset), .din(mosi), .dout(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_sync, ss_sync, mosi_rise, mosi_fall};

    spi_state_e            state_q, state_d;
    logic [CntW-1:0]       bit_cnt_q;
    logic [DATA_WIDTH-1:0] tx_shift_q, rx_shift_q, rx_data_q, hold_q;
    logic                  hold_full_q;
    logic                  rx_valid_q, tx_underrun_q, frame_error_q;

    logic do_load, do_sample, do_shift, word_done, frame_abort, accept;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // ss_n rise takes priority over any sclk edge seen in the same cycle.
    always_comb begin
        state_d     = state_q;
        do_load     = 1'b0;
        do_sample   = 1'b0;
        do_shift    = 1'b0;
        word_done   = 1'b0;
        frame_abort = 1'b0;
        if (ss_rise) begin
            state_d     = StIdle;
            frame_abort = (state_q == StShift) && (bit_cnt_q != '0);
        end else begin
            unique case (state_q)
                StIdle: if (ss_fall) state_d = StLoad;
                StLoad: begin
                    do_load = 1'b1;
                    state_d = StShift;
                end
                StShift: begin
                    if (sclk_rise) begin
                        do_sample = 1'b1;
                        if (bit_cnt_q == LastBit) begin
                            word_done = 1'b1;
                            state_d   = StLoad;
                        end
                    end else if (sclk_fall && bit_cnt_q != '0) begin
                        // bit_cnt==0 fall follows the final rise of the previous word.
                        do_shift = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign accept = bus.tx_valid & ~hold_full_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q     <= '0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_error_q <= frame_abort;
            if (ss_rise) bit_cnt_q <= '0;

            if (accept) begin
                hold_q      <= bus.tx_data;
                hold_full_q <= 1'b1;
            end else if (do_load && hold_full_q) begin
                hold_full_q <= 1'b0;
            end

            if (do_load) begin
                bit_cnt_q <= '0;
                if (hold_full_q) begin
                    tx_shift_q <= hold_q;
                end else begin
                    tx_shift_q    <= '0;
                    tx_underrun_q <= 1'b1;
                end
            end

            if (do_sample) begin
                rx_shift_q <= {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};
                if (word_done) begin
                    rx_data_q  <= {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};
                    rx_valid_q <= 1'b1;
                    bit_cnt_q  <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + CntW'(1);
                end
            end

            if (do_shift) tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    assign bus.busy        = (state_q != StIdle);
    assign bus.tx_ready    = ~hold_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.frame_error = frame_error_q;
    assign miso_oe         = bus.busy;
    assign miso            = bus.busy & tx_shift_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a bit-banged mode-0 master at sclk = clk/8 plus a
// strobe monitor.
module tb_spi_slave_core;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic reset, sclk, ss_n, mosi, miso, miso_oe;

    spi_slave_core_if #(.DATA_WIDTH(32)) bus ();

    spi_slave_core #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Strobe monitor; und_at_rx records underruns seen up to the latest rx_valid.
    int rx_cnt = 0, und_cnt = 0, fe_cnt = 0, und_at_rx = 0;
    logic [31:0] rx_log [$];
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_cnt++;
            und_at_rx = und_cnt;
            rx_log.push_back(bus.rx_data);
        end
        if (bus.tx_underrun) und_cnt++;
        if (bus.frame_error) fe_cnt++;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [31:0] d);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    // Master drives mosi on fall, samples miso just before raising sclk.
    task automatic xfer(input logic [31:0] mw, input int nbits, output logic [31:0] sw);
        logic [31:0] w = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mw[31-i];
            clks(4);
            w = {w[30:0], miso};
            sclk = 1'b1;
            clks(4);
            sclk = 1'b0;
        end
        sw = w;
    endtask

    task automatic frame(input logic [31:0] mw, output logic [31:0] sw);
        ss_n = 1'b0;
        clks(8);
        xfer(mw, 32, sw);
        clks(4);
        ss_n = 1'b1;
        clks(8);
    endtask

    logic [31:0] sw, s0, s1, s2;
    int rx0, und0, fe0;

    initial begin
        reset = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        bus.tx_data = '0; bus.tx_valid = 1'b0;
        clks(4);
        check("reset tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset miso_oe", {31'd0, miso_oe}, 32'd0);
        check("reset rx_data", bus.rx_data, 32'd0);
        check("reset strobes", {29'd0, bus.rx_valid, bus.tx_underrun, bus.frame_error}, 32'd0);
        reset = 1'b0;
        clks(6);

        // Basic word
        check("basic tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        tx_write(32'hA5A5_0F0F);
        rx0 = rx_cnt; und0 = und_cnt;
        frame(32'h1234_5678, sw);
        check("basic miso", sw, 32'hA5A5_0F0F);
        check("basic rx_data", rx_log[$], 32'h1234_5678);
        check("basic rx count", rx_cnt - rx0, 1);
        check("basic underruns", und_at_rx - und0, 0);

        // Empty TX
        rx0 = rx_cnt; und0 = und_cnt;
        frame(32'hFFFF_FFFF, sw);
        check("empty miso", sw, 32'h0);
        check("empty underruns", und_at_rx - und0, 1);
        check("empty rx_data", rx_log[$], 32'hFFFF_FFFF);
        check("empty rx count", rx_cnt - rx0, 1);

        // Burst of 3 words with ss_n held low
        tx_write(32'hDEAD_BEEF);
        rx0 = rx_cnt; und0 = und_cnt;
        fork
            begin
                ss_n = 1'b0;
                clks(8);
                xfer(32'hCAFE_0001, 32, s0);
                xfer(32'h7E57_0002, 32, s1);
                xfer(32'h0BAD_F00D, 32, s2);
                clks(4);
                ss_n = 1'b1;
                clks(8);
            end
            begin
                logic [31:0] nxt [3] = '{32'h0123_4567, 32'h89AB_CDEF, 32'h5555_AAAA};
                for (int k = 0; k < 3; k++) begin
                    for (int c = 0; c < 600 && !bus.tx_ready; c++) clks(1);
                    check("burst tx_ready rise", {31'd0, bus.tx_ready}, 32'd1);
                    tx_write(nxt[k]);
                end
            end
        join
        check("burst rx count", rx_cnt - rx0, 3);
        check("burst rx0", rx_log[rx_log.size()-3], 32'hCAFE_0001);
        check("burst rx1", rx_log[rx_log.size()-2], 32'h7E57_0002);
        check("burst rx2", rx_log[rx_log.size()-1], 32'h0BAD_F00D);
        check("burst miso0", s0, 32'hDEAD_BEEF);
        check("burst miso1", s1, 32'h0123_4567);
        check("burst miso2", s2, 32'h89AB_CDEF);
        check("burst underruns", und_cnt - und0, 0);

        // Abort after 13 bits, then a clean frame
        rx0 = rx_cnt; fe0 = fe_cnt;
        ss_n = 1'b0;
        clks(8);
        xfer(32'hFFFF_FFFF, 13, sw);
        clks(4);
        ss_n = 1'b1;
        clks(8);
        check("abort frame_error cycles", fe_cnt - fe0, 1);
        check("abort rx count", rx_cnt - rx0, 0);
        frame(32'hC3C3_5A5A, sw);
        check("after abort rx_data", rx_log[$], 32'hC3C3_5A5A);
        check("after abort rx count", rx_cnt - rx0, 1);

        // Reset at bit 20 with ss_n still low
        tx_write(32'h1111_2222);
        rx0 = rx_cnt; fe0 = fe_cnt;
        ss_n = 1'b0;
        clks(8);
        xfer(32'hF0F0_F0F0, 20, sw);
        tx_write(32'h3333_4444);
        check("pre-reset tx_ready", {31'd0, bus.tx_ready}, 32'd0);
        check("pre-reset busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        clks(1);
        check("midrst tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        check("midrst miso_oe/miso", {30'd0, miso_oe, miso}, 32'd0);
        check("midrst busy", {31'd0, bus.busy}, 32'd0);
        check("midrst rx_data", bus.rx_data, 32'd0);
        check("midrst strobes", {29'd0, bus.rx_valid, bus.tx_underrun, bus.frame_error}, 32'd0);
        clks(2);
        reset = 1'b0;
        clks(16);
        check("no frame without fresh fall", {31'd0, bus.busy}, 32'd0);
        ss_n = 1'b1;
        clks(8);
        check("midrst rx count", rx_cnt - rx0, 0);
        check("midrst frame_error", fe_cnt - fe0, 0);

        // sclk/mosi glitches with ss_n high
        rx0 = rx_cnt;
        for (int i = 0; i < 40; i++) begin
            sclk = ~sclk;
            mosi = i[1];
            clks(1 + (i % 3));
        end
        sclk = 1'b0;
        check("glitch busy/miso_oe", {30'd0, bus.busy, miso_oe}, 32'd0);
        clks(8);
        check("glitch rx count", rx_cnt - rx0, 0);
        frame(32'h0F0F_F0F0, sw);
        check("post glitch rx_data", rx_log[$], 32'h0F0F_F0F0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
